nibble_serial_add_seq: RTL and testbench
========================================

Name: nibble_serial_add_seq

Overview:
Sequencer that performs WIDTH-bit additions on the team's 4-bit ripple-carry adder, one nibble per clock. It sits around the adder: upstream it drives the adder's operand and carry-in pins, downstream it consumes the adder's result and carry-out. The carry is registered between nibbles. Operands enter through a valid/ready handshake; the assembled sum leaves through a valid/ready handshake.

Parameters:
WIDTH, 16, operand/sum width in bits; must be a multiple of 4 and at least 4.
NIBBLES, WIDTH/4, derived nibble count; not overridden.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  operand request valid
in_ready  output  1  sequencer can accept an operand pair
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_ci  input  1  carry-in for bit 0
add_r1  output  4  nibble of A to the adder
add_r2  output  4  nibble of B to the adder
add_ci  output  1  carry to the adder
add_result  input  4  adder sum nibble (combinational, same cycle)
add_carry  input  1  adder carry-out (combinational, same cycle)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts the result
out_sum  output  WIDTH  assembled sum
out_carry  output  1  final carry-out

Behaviour:
- States: IDLE, RUN, DONE. Registers: a_reg, b_reg, sum_reg, carry_reg, idx (ceil(log2(NIBBLES)) bits, minimum 1).
- Reset, when sampled high: state=IDLE, idx=0, carry_reg=0, sum_reg=0, out_valid=0, out_sum=0, out_carry=0. The operand registers are also cleared.
- Reset mid-operation discards the operation in progress, with no output produced. in_ready=1 on the first cycle after reset.
- IDLE:
  - in_ready=1.
  - add_r1, add_r2 and add_ci are driven to 0.
  - If in_valid=1: capture in_a, in_b; set carry_reg=in_ci and idx=0; go to RUN.
- RUN:
  - in_ready=0.
  - add_r1=a_reg[4*idx+3:4*idx], add_r2=b_reg[4*idx+3:4*idx], add_ci=carry_reg.
  - Each cycle: sum_reg[4*idx+3:4*idx] <= add_result; carry_reg <= add_carry; idx <= idx+1.
  - When idx==NIBBLES-1, go to DONE instead of incrementing idx.
- DONE:
  - out_valid=1, out_sum=sum_reg, out_carry=carry_reg, in_ready=0.
  - Outputs hold stable while out_ready=0.
  - When out_ready=1: transfer completes, go to IDLE, and out_valid drops the next cycle.
  - A new operand cannot be accepted in the same cycle as the output transfer.
- Latency: accept edge T → RUN for cycles T+1..T+NIBBLES → out_valid high from cycle T+NIBBLES+1. With WIDTH=16, out_valid rises 5 cycles after acceptance.
- Throughput: one operation per NIBBLES+2 cycles at most.
- in_valid while in RUN or DONE is ignored; the source must hold its request until in_ready=1.
- Arithmetic is modulo 2^WIDTH; overflow is reported only through out_carry. All nibble indexing is little-endian, with nibble 0 = bits 3:0.
- The adder path is purely combinational inside one cycle. The sequencer registers only its own state, not the adder pins.
- WIDTH=4 degenerates to RUN for a single cycle.
- No X on any output after reset.

Test Plan:
(All with WIDTH=16 unless noted.)
- Basic add: in_a=0x1234, in_b=0x4321, in_ci=0 accepted at cycle T → out_valid at T+5, out_sum=0x5555, out_carry=0.
- Full carry ripple across nibbles: in_a=0xFFFF, in_b=0x0001, in_ci=0 → out_sum=0x0000, out_carry=1. add_ci is observed as 0,1,1,1 over the four RUN cycles.
- Max operands with carry-in: in_a=0xFFFF, in_b=0xFFFF, in_ci=1 → out_sum=0xFFFF, out_carry=1.
- Nibble order: in_a=0xA5C3, in_b=0x0000 → add_r1 sequence is 0x3, 0xC, 0x5, 0xA on consecutive RUN cycles.
- Backpressure:
  - Hold out_ready=0 for 3 cycles after out_valid rises, with in_valid=1 throughout.
  - Required: out_sum and out_carry stay stable and in_ready stays 0.
  - On the out_ready=1 cycle the transfer completes; in_ready=1 on the next cycle, and only then is the new operand accepted.
- Reset mid-run:
  - Assert reset for one cycle during the 2nd RUN cycle.
  - Required: next cycle is IDLE, out_valid=0, in_ready=1, and no result is emitted.
  - A following 0x0F0F+0x00F1 with ci=0 yields 0x1000, carry 0.

Source files
------------

// File: rtl/nibble_serial_add_seq.sv
// WIDTH-bit adder built by stepping an external 4-bit ripple-carry adder
// over the operands one nibble per clock, little-endian.
module nibble_serial_add_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_ci,
  output logic [3:0]       add_r1,
  output logic [3:0]       add_r2,
  output logic             add_ci,
  input  logic [3:0]       add_result,
  input  logic             add_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  // state   | meaning
  // S_IDLE  | waiting for an operand pair, in_ready high
  // S_RUN   | one nibble through the adder per cycle
  // S_DONE  | sum presented, held until out_ready
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [IDX_W-1:0] r_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_carry <= in_ci;
            r_idx   <= '0;
          end
        end
        S_RUN: begin
          for (int n = 0; n < NIBBLES; n++) begin
            if (r_idx == IDX_W'(n)) r_sum[4*n +: 4] <= add_result;
          end
          r_carry <= add_carry;
          // idx parks on the last nibble; the next accept clears it
          if (r_idx != LAST_IDX) r_idx <= r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    add_r1      = 4'd0;
    add_r2      = 4'd0;
    add_ci      = 1'b0;
    out_valid   = 1'b0;
    out_sum     = '0;
    out_carry   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        for (int n = 0; n < NIBBLES; n++) begin
          if (r_idx == IDX_W'(n)) begin
            add_r1 = r_a[4*n +: 4];
            add_r2 = r_b[4*n +: 4];
          end
        end
        add_ci = r_carry;
        if (r_idx == LAST_IDX) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        out_sum   = r_sum;
        out_carry = r_carry;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_nibble_serial_add_seq.sv
// Directed bench for nibble_serial_add_seq with a behavioural 4-bit adder and
// a queue-based scoreboard popped by an independent output monitor.
module tb_nibble_serial_add_seq;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             in_ci = 1'b0;
  logic [3:0]       add_r1;
  logic [3:0]       add_r2;
  logic             add_ci;
  logic [3:0]       add_result;
  logic             add_carry;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [WIDTH:0]   exp_nxt = '0;
  logic [WIDTH:0]   exp_q[$];
  int               acc_q[$];
  logic [WIDTH:0]   exp_pop;
  int               acc_pop;
  logic             prev_valid = 1'b0;
  logic [WIDTH-1:0] hold_sum = '0;
  logic             hold_carry = 1'b0;

  nibble_serial_add_seq #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_ci      (in_ci),
    .add_r1     (add_r1),
    .add_r2     (add_r2),
    .add_ci     (add_ci),
    .add_result (add_result),
    .add_carry  (add_carry),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_carry  (out_carry)
  );

  // the team's 4-bit ripple-carry adder, modelled behaviourally
  assign {add_carry, add_result} = {1'b0, add_r1} + {1'b0, add_r2} + {4'd0, add_ci};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // handshake capture and output checking, sampled mid-cycle
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      acc_q.delete();
      prev_valid = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(exp_nxt);
        acc_q.push_back(cyc);
      end
      if (out_valid && !prev_valid) begin
        if (acc_q.size() == 0) chk("unexpected_out_valid", 32'(out_valid), 32'd0);
        else begin
          acc_pop = acc_q.pop_front();
          chk("latency", 32'(cyc - acc_pop), 32'd5);
        end
        hold_sum   = out_sum;
        hold_carry = out_carry;
      end else if (out_valid) begin
        chk("hold_sum", 32'(out_sum), 32'(hold_sum));
        chk("hold_carry", 32'(out_carry), 32'(hold_carry));
        chk("hold_in_ready", 32'(in_ready), 32'd0);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_transfer", 32'(out_valid), 32'd0);
        else begin
          exp_pop = exp_q.pop_front();
          chk("out_sum", 32'(out_sum), 32'(exp_pop[WIDTH-1:0]));
          chk("out_carry", 32'(out_carry), 32'(exp_pop[WIDTH]));
        end
      end
      prev_valid = out_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (in_ready !== 1'b1) chk("in_ready_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic ci,
                       input logic [WIDTH-1:0] s, input logic co, input bit hold);
    wait_ready();
    in_a     = a;
    in_b     = b;
    in_ci    = ci;
    exp_nxt  = {co, s};
    in_valid = 1'b1;
    tick();
    if (!hold) in_valid = 1'b0;
  endtask

  // expects to be called on the first RUN cycle; returns on the DONE cycle
  task automatic run_checks(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic ci);
    logic       c;
    logic [4:0] s;
    logic [3:0] an;
    logic [3:0] bn;
    c = ci;
    for (int n = 0; n < WIDTH/4; n++) begin
      an = a[4*n +: 4];
      bn = b[4*n +: 4];
      chk("add_r1", 32'(add_r1), 32'(an));
      chk("add_r2", 32'(add_r2), 32'(bn));
      chk("add_ci", 32'(add_ci), 32'(c));
      chk("run_in_ready", 32'(in_ready), 32'd0);
      s = {1'b0, an} + {1'b0, bn} + {4'd0, c};
      c = s[4];
      tick();
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    chk("rst_out_carry", 32'(out_carry), 32'd0);
    chk("rst_add_r1", 32'(add_r1), 32'd0);
    chk("rst_add_ci", 32'(add_ci), 32'd0);
    reset = 1'b0;
    tick();

    issue(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_checks(16'h1234, 16'h4321, 1'b0);
    drain();

    issue(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_checks(16'hFFFF, 16'h0001, 1'b0);
    drain();

    issue(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    run_checks(16'hFFFF, 16'hFFFF, 1'b1);
    drain();

    issue(16'hA5C3, 16'h0000, 1'b0, 16'hA5C3, 1'b0, 1'b0);
    run_checks(16'hA5C3, 16'h0000, 1'b0);
    drain();

    // backpressure with the next request already waiting
    out_ready = 1'b0;
    issue(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    in_a    = 16'h0001;
    in_b    = 16'h0002;
    in_ci   = 1'b1;
    exp_nxt = {1'b0, 16'h0004};
    run_checks(16'h8000, 16'h8000, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    chk("xfer_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("post_xfer_in_ready", 32'(in_ready), 32'd1);
    chk("post_xfer_out_valid", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    run_checks(16'h0001, 16'h0002, 1'b1);
    drain();

    // reset during the second RUN cycle
    issue(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_add_ci", 32'(add_ci), 32'd0);
    for (int k = 0; k < 8; k++) begin
      chk("no_result_after_reset", 32'(out_valid), 32'd0);
      tick();
    end

    issue(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);
    run_checks(16'h0F0F, 16'h00F1, 1'b0);
    drain();

    tick();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
